// File: rtl/id_stage_pipelined_if.sv
// Fetch, write-back and execute-side signals of the pipelined decode stage.
interface id_stage_pipelined_if #(
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [PC_WIDTH-1:0]   in_pc;
  logic [INST_WIDTH-1:0] in_inst;
  logic                  flush;
  logic                  wb_we;
  logic [4:0]            wb_rd;
  logic [DWIDTH-1:0]     wb_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [PC_WIDTH-1:0]   out_pc;
  logic [4:0]            out_rs1;
  logic [4:0]            out_rs2;
  logic [4:0]            out_rd;
  logic [DWIDTH-1:0]     out_rs1_data;
  logic [DWIDTH-1:0]     out_rs2_data;
  logic [DWIDTH-1:0]     out_imm;
  logic [1:0]            out_alu_op;
  logic [1:0]            out_alu_src_a;
  logic [1:0]            out_alu_src_b;
  logic                  out_reg_we;
  logic                  out_mem_read;
  logic                  out_mem_write;
  logic                  out_mem_to_reg;
  logic                  out_illegal;
  logic [CNT_WIDTH-1:0]  stall_cnt;

  modport master (
    output in_valid, in_pc, in_inst, flush, wb_we, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_rs1_data, out_rs2_data,
           out_imm, out_alu_op, out_alu_src_a, out_alu_src_b, out_reg_we, out_mem_read,
           out_mem_write, out_mem_to_reg, out_illegal, stall_cnt
  );

  modport slave (
    input  in_valid, in_pc, in_inst, flush, wb_we, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_rs1_data, out_rs2_data,
           out_imm, out_alu_op, out_alu_src_a, out_alu_src_b, out_reg_we, out_mem_read,
           out_mem_write, out_mem_to_reg, out_illegal, stall_cnt
  );
endinterface

// File: rtl/id_stage_pipelined.sv
// RV32I/E decode stage: register file, decoder, registered ID/EX bundle, load-use bubbles.
// Define ID_WB_BYPASS_EN to forward same-cycle write-back data into captured/held operands.
module id_stage_pipelined #(
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned NREG       = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic                 clk,
  input logic                 rst,
  id_stage_pipelined_if.slave bus_io
);
  localparam int unsigned AW = $clog2(NREG);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  function automatic logic idx_ok(input logic [4:0] idx);
    return 32'(idx) < NREG;
  endfunction

  logic [DWIDTH-1:0] rf_q [NREG];

  always_ff @(posedge clk) begin
    if (bus_io.wb_we && bus_io.wb_rd != 5'd0 && idx_ok(bus_io.wb_rd)) begin
      rf_q[bus_io.wb_rd[AW-1:0]] <= bus_io.wb_data;
    end
  end

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  assign inst   = bus_io.in_inst[31:0];
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  logic [DWIDTH-1:0] rs1_raw, rs2_raw, rs1_val, rs2_val;
  assign rs1_raw = (rs1 == 5'd0) ? '0 : rf_q[rs1[AW-1:0]];
  assign rs2_raw = (rs2 == 5'd0) ? '0 : rf_q[rs2[AW-1:0]];

`ifdef ID_WB_BYPASS_EN
  assign rs1_val = (bus_io.wb_we && rs1 != 5'd0 && rs1 == bus_io.wb_rd) ? bus_io.wb_data : rs1_raw;
  assign rs2_val = (bus_io.wb_we && rs2 != 5'd0 && rs2 == bus_io.wb_rd) ? bus_io.wb_data : rs2_raw;
`else
  assign rs1_val = rs1_raw;
  assign rs2_val = rs2_raw;
`endif

  logic [31:0] imm32;
  logic [1:0]  alu_op, src_a, src_b;
  logic        dec_we, reg_we, mem_read, mem_write, mem_to_reg;
  logic        use_rs1, use_rs2, known, illegal;

  always_comb begin
    imm32      = '0;
    alu_op     = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    dec_we     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    known      = 1'b1;
    case (opcode)
      OpR: begin
        alu_op = 2'b10; dec_we = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OpImm: begin
        alu_op = 2'b11; src_b = 2'b01; dec_we = 1'b1; use_rs1 = 1'b1;
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      OpLoad: begin
        src_b = 2'b01; dec_we = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; use_rs1 = 1'b1;
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      OpStore: begin
        src_b = 2'b01; mem_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OpBranch: begin
        alu_op = 2'b01; use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OpJal: begin
        src_a = 2'b01; src_b = 2'b10; dec_we = 1'b1;
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OpJalr: begin
        src_a = 2'b01; src_b = 2'b10; dec_we = 1'b1; use_rs1 = 1'b1;
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      OpLui: begin
        src_a = 2'b10; src_b = 2'b01; dec_we = 1'b1;
        imm32 = {inst[31:12], 12'b0};
      end
      OpAuipc: begin
        src_a = 2'b01; src_b = 2'b01; dec_we = 1'b1;
        imm32 = {inst[31:12], 12'b0};
      end
      default: known = 1'b0;
    endcase
    illegal = !known || (use_rs1 && !idx_ok(rs1)) || (use_rs2 && !idx_ok(rs2)) ||
              (dec_we && !idx_ok(rd));
    reg_we = dec_we;
    // Illegal entries still flow downstream but must have no architectural side effects.
    if (illegal) begin
      reg_we     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
    end
  end

  logic                 valid_q, reg_we_q, mem_read_q, mem_write_q, mem_to_reg_q, illegal_q;
  logic [PC_WIDTH-1:0]  pc_q;
  logic [4:0]           rs1_q, rs2_q, rd_q;
  logic [DWIDTH-1:0]    rs1_data_q, rs2_data_q, imm_q;
  logic [1:0]           alu_op_q, src_a_q, src_b_q;
  logic [CNT_WIDTH-1:0] stall_q;

  logic hold, hazard;
  assign hold   = valid_q && !bus_io.out_ready;
  assign hazard = valid_q && mem_read_q && rd_q != 5'd0 && bus_io.in_valid &&
                  ((use_rs1 && rs1 == rd_q) || (use_rs2 && rs2 == rd_q));

  assign bus_io.in_ready = !rst && (bus_io.flush || (!hold && !hazard));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      alu_op_q     <= '0;
      src_a_q      <= '0;
      src_b_q      <= '0;
      reg_we_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      illegal_q    <= 1'b0;
      stall_q      <= '0;
    end else if (bus_io.flush) begin
      valid_q <= 1'b0;
    end else if (hold) begin
`ifdef ID_WB_BYPASS_EN
      if (bus_io.wb_we && rs1_q != 5'd0 && rs1_q == bus_io.wb_rd) rs1_data_q <= bus_io.wb_data;
      if (bus_io.wb_we && rs2_q != 5'd0 && rs2_q == bus_io.wb_rd) rs2_data_q <= bus_io.wb_data;
`endif
    end else if (hazard) begin
      valid_q <= 1'b0;
      if (stall_q != '1) stall_q <= stall_q + CNT_WIDTH'(1);
    end else if (bus_io.in_valid) begin
      valid_q      <= 1'b1;
      pc_q         <= bus_io.in_pc;
      rs1_q        <= rs1;
      rs2_q        <= rs2;
      rd_q         <= rd;
      rs1_data_q   <= rs1_val;
      rs2_data_q   <= rs2_val;
      imm_q        <= DWIDTH'($signed(imm32));
      alu_op_q     <= alu_op;
      src_a_q      <= src_a;
      src_b_q      <= src_b;
      reg_we_q     <= reg_we;
      mem_read_q   <= mem_read;
      mem_write_q  <= mem_write;
      mem_to_reg_q <= mem_to_reg;
      illegal_q    <= illegal;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus_io.out_valid      = valid_q;
  assign bus_io.out_pc         = pc_q;
  assign bus_io.out_rs1        = rs1_q;
  assign bus_io.out_rs2        = rs2_q;
  assign bus_io.out_rd         = rd_q;
  assign bus_io.out_rs1_data   = rs1_data_q;
  assign bus_io.out_rs2_data   = rs2_data_q;
  assign bus_io.out_imm        = imm_q;
  assign bus_io.out_alu_op     = alu_op_q;
  assign bus_io.out_alu_src_a  = src_a_q;
  assign bus_io.out_alu_src_b  = src_b_q;
  assign bus_io.out_reg_we     = reg_we_q;
  assign bus_io.out_mem_read   = mem_read_q;
  assign bus_io.out_mem_write  = mem_write_q;
  assign bus_io.out_mem_to_reg = mem_to_reg_q;
  assign bus_io.out_illegal    = illegal_q;
  assign bus_io.stall_cnt      = stall_q;
endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed, table-driven bench for id_stage_pipelined (RV32I instance plus an RV32E instance).
module tb_id_stage_pipelined;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_pipelined_if #(.INST_WIDTH(32), .DWIDTH(32), .PC_WIDTH(32), .CNT_WIDTH(16)) bus ();
  id_stage_pipelined_if #(.INST_WIDTH(32), .DWIDTH(32), .PC_WIDTH(32), .CNT_WIDTH(16)) bus_e ();

  id_stage_pipelined #(
    .INST_WIDTH(32), .DWIDTH(32), .PC_WIDTH(32), .NREG(32), .CNT_WIDTH(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  id_stage_pipelined #(
    .INST_WIDTH(32), .DWIDTH(32), .PC_WIDTH(32), .NREG(16), .CNT_WIDTH(16)
  ) dut_e (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_e)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    bus.wb_we = 1'b1; bus.wb_rd = r; bus.wb_data = d;
    step();
    bus.wb_we = 1'b0;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [1:0]  op;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [4:0]  ctl;   // {reg_we, mem_read, mem_write, mem_to_reg, illegal}
    logic        chk;
    logic [31:0] rs1d;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [4:0] ctl_of();
    return {bus.out_reg_we, bus.out_mem_read, bus.out_mem_write, bus.out_mem_to_reg,
            bus.out_illegal};
  endfunction

  initial begin
    logic [31:0] exp_byp;
    vecs[0]  = '{32'hFFF08293, 32'hFFFFFFFF, 2'b11, 2'b00, 2'b01, 5'b10000, 1'b1, 32'd7};
    vecs[1]  = '{32'h00208233, 32'h00000000, 2'b10, 2'b00, 2'b00, 5'b10000, 1'b1, 32'd7};
    vecs[2]  = '{32'h00812183, 32'h00000008, 2'b00, 2'b00, 2'b01, 5'b11010, 1'b1, 32'h100};
    vecs[3]  = '{32'hFE112E23, 32'hFFFFFFFC, 2'b00, 2'b00, 2'b01, 5'b00100, 1'b1, 32'h100};
    vecs[4]  = '{32'hFE208CE3, 32'hFFFFFFF8, 2'b01, 2'b00, 2'b00, 5'b00000, 1'b1, 32'd7};
    vecs[5]  = '{32'h001000EF, 32'h00000800, 2'b00, 2'b01, 2'b10, 5'b10000, 1'b0, 32'd0};
    vecs[6]  = '{32'h123452B7, 32'h12345000, 2'b00, 2'b10, 2'b01, 5'b10000, 1'b0, 32'd0};
    vecs[7]  = '{32'hFFFFF297, 32'hFFFFF000, 2'b00, 2'b01, 2'b01, 5'b10000, 1'b0, 32'd0};
    vecs[8]  = '{32'h004100E7, 32'h00000004, 2'b00, 2'b01, 2'b10, 5'b10000, 1'b1, 32'h100};
    vecs[9]  = '{32'h0000000B, 32'h00000000, 2'b00, 2'b00, 2'b00, 5'b00001, 1'b1, 32'd0};
    vecs[10] = '{32'h00000233, 32'h00000000, 2'b10, 2'b00, 2'b00, 5'b10000, 1'b1, 32'd0};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0; bus.flush = 1'b0;
    bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0; bus.out_ready = 1'b1;
    bus_e.in_valid = 1'b0; bus_e.in_pc = '0; bus_e.in_inst = '0; bus_e.flush = 1'b0;
    bus_e.wb_we = 1'b0; bus_e.wb_rd = '0; bus_e.wb_data = '0; bus_e.out_ready = 1'b1;

    // Reset state
    step();
    step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("rst_out_imm", bus.out_imm, 32'd0);
    check("rst_out_pc", bus.out_pc, 32'd0);
    check("rst_ctl", 32'(ctl_of()), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Populate registers; the x0 write must be ignored
    wb_write(5'd0, 32'hDEAD);
    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'h100);
    wb_write(5'd6, 32'h55);

    for (int i = 0; i < 11; i++) begin
      bus.in_valid = 1'b1;
      bus.in_inst  = vecs[i].inst;
      bus.in_pc    = 32'h1000 + 32'(i) * 4;
      step();
      bus.in_valid = 1'b0;
      check($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("v%0d_pc", i), bus.out_pc, 32'h1000 + 32'(i) * 4);
      check($sformatf("v%0d_imm", i), bus.out_imm, vecs[i].imm);
      check($sformatf("v%0d_sel", i), {26'd0, bus.out_alu_op, bus.out_alu_src_a, bus.out_alu_src_b},
            {26'd0, vecs[i].op, vecs[i].sa, vecs[i].sb});
      check($sformatf("v%0d_ctl", i), 32'(ctl_of()), 32'(vecs[i].ctl));
      if (vecs[i].chk) check($sformatf("v%0d_rs1d", i), bus.out_rs1_data, vecs[i].rs1d);
      step();
    end

    // Load-use: lw x3,0(x2) then add x4,x3,x1
    check("lu_cnt_before", 32'(bus.stall_cnt), 32'd0);
    bus.in_valid = 1'b1; bus.in_inst = 32'h00012183; bus.in_pc = 32'h2000;
    step();
    bus.in_inst = 32'h00118233; bus.in_pc = 32'h2004;
    #1;
    check("lu_in_ready_stall", 32'(bus.in_ready), 32'd0);
    step();
    check("lu_bubble", 32'(bus.out_valid), 32'd0);
    check("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    check("lu_in_ready_resume", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("lu_add_valid", 32'(bus.out_valid), 32'd1);
    check("lu_add_pc", bus.out_pc, 32'h2004);
    check("lu_add_rs1", 32'(bus.out_rs1), 32'd3);
    check("lu_add_op", 32'(bus.out_alu_op), 32'd2);
    step();

    // Flush during back-pressure
    bus.in_valid = 1'b1; bus.in_inst = 32'hFFF08293; bus.in_pc = 32'h3000;
    step();
    bus.out_ready = 1'b0;
    bus.in_inst = 32'h00208233; bus.in_pc = 32'h3004;
    #1;
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    check("bp_hold_pc", bus.out_pc, 32'h3000);
    bus.flush = 1'b1; bus.in_inst = 32'h123452B7; bus.in_pc = 32'h3008;
    #1;
    check("fl_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    check("fl_valid", 32'(bus.out_valid), 32'd0);
    step();
    check("fl_dropped", 32'(bus.out_valid), 32'd0);

    // Same-cycle write-back of x6 while decoding add x7,x6,x0
`ifdef ID_WB_BYPASS_EN
    exp_byp = 32'h1234;
`else
    exp_byp = 32'h55;
`endif
    bus.in_valid = 1'b1; bus.in_inst = 32'h000303B3; bus.in_pc = 32'h4000;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd6; bus.wb_data = 32'h1234;
    step();
    bus.wb_we = 1'b0;
    check("byp_rs1d", bus.out_rs1_data, exp_byp);
    step();
    check("byp_later_rs1d", bus.out_rs1_data, 32'h1234);
    bus.in_valid = 1'b0;
    step();

    // Asynchronous reset while the bundle is held; RF contents survive
    bus.in_valid = 1'b1; bus.in_inst = 32'hFFF08293; bus.in_pc = 32'h5000;
    step();
    bus.out_ready = 1'b0; bus.in_inst = 32'h00208233;
    step();
    check("mrst_held", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mrst_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_in_ready", 32'(bus.in_ready), 32'd0);
    check("mrst_pc", bus.out_pc, 32'd0);
    check("mrst_cnt", 32'(bus.stall_cnt), 32'd0);
    step();
    rst = 1'b0; bus.out_ready = 1'b1; bus.in_inst = 32'h00208233; bus.in_pc = 32'h5004;
    step();
    bus.in_valid = 1'b0;
    check("mrst_rf_kept", bus.out_rs1_data, 32'd7);
    check("mrst_rf_kept2", bus.out_rs2_data, 32'h100);

    // RV32E: add x17,x1,x2 names a register beyond x15
    bus_e.in_valid = 1'b1; bus_e.in_inst = 32'h002088B3; bus_e.in_pc = 32'h6000;
    step();
    bus_e.in_valid = 1'b0;
    check("e_valid", 32'(bus_e.out_valid), 32'd1);
    check("e_illegal", 32'(bus_e.out_illegal), 32'd1);
    check("e_reg_we", 32'(bus_e.out_reg_we), 32'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
